// File: rtl/mac_pkg.sv
// Shared widths and state encoding for the product accumulator.
package mac_pkg;
    localparam int PROD_W_DEF  = 128;
    localparam int GUARD_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    function automatic int acc_width(input int prod_w, input int guard_w);
        return prod_w + guard_w;
    endfunction

    localparam int ACC_W_DEF = acc_width(PROD_W_DEF, GUARD_W_DEF);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;
endpackage

// File: rtl/mac_accumulator.sv
// Accumulates multiplier products into a guarded sum; one registered result per packet, 1 cycle after the last beat.
// Input stalls only while a result is pending and out_ready is low; handshake and a new last beat may share a cycle.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int GUARD_W = GUARD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int ACC_W  = acc_width(PROD_W, GUARD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   acc_base;
    logic [CNT_W-1:0]   cnt_base, cnt_inc;
    logic               ovf_base, ovf_upd, cnt_sat;
    logic [ACC_W:0]     sum;
    logic               beat_acc, out_hs;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        // clr zeroes the bases so a beat in the same cycle starts a fresh packet
        acc_base = clr ? '0 : acc_q;
        cnt_base = clr ? '0 : cnt_q;
        ovf_base = clr ? 1'b0 : ovf_q;

        sum      = {1'b0, acc_base} + {{(GUARD_W + 1){1'b0}}, in_data};
        cnt_sat  = &cnt_base;
        cnt_inc  = cnt_sat ? cnt_base : cnt_base + {{(CNT_W - 1){1'b0}}, 1'b1};
        ovf_upd  = ovf_base | sum[ACC_W] | cnt_sat;

        beat_acc = in_valid && in_ready;
        out_hs   = out_valid && out_ready;

        state_d     = state_q;
        acc_d       = acc_base;
        cnt_d       = cnt_base;
        ovf_d       = ovf_base;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (out_hs) begin
            state_d = ACCUM;
        end

        if (beat_acc) begin
            if (in_last) begin
                out_data_d  = sum[ACC_W-1:0];
                out_count_d = cnt_inc;
                out_ovf_d   = ovf_upd;
                state_d     = HOLD;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_inc;
                ovf_d = ovf_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage of the 64x64 combinational multiplier. Consumes its 128-bit products through a valid/ready stream and accumulates them into a guarded accumulator.
- Emits one registered dot-product result per packet, where a packet ends on a beat flagged last.
- Provides the registered boundary after the multiplier's long combinational adder tree.

Parameters:
- PROD_W, 128, width of each incoming product.
- GUARD_W, 8, guard bits above PROD_W. Accumulator width ACC_W = PROD_W+GUARD_W.
- CNT_W, 16, width of the per-packet term counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  PROD_W  unsigned product.
- in_last  in  1  beat is the final term of the packet.
- clr  in  1  abort the current accumulation (synchronous pulse).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  accumulated sum, modulo 2^ACC_W.
- out_count  out  CNT_W  number of terms in the packet.
- out_ovf  out  1  sticky overflow for the packet.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high, on ports clk and rst.
- Reset: acc=0, cnt=0, ovf_st=0, out_valid=0, out_data=0, out_count=0, out_ovf=0, state=ACCUM. Reset mid-packet discards partial sums and any pending result.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. Input is blocked only while a result is pending and stalled.
- Accepted beat, not last:
  - acc <= acc_base + zext(in_data). The sum wraps mod 2^ACC_W.
  - cnt <= cnt_base + 1, saturating at 2^CNT_W-1.
  - ovf_st <= ovf_base | carry-out | count saturation.
- Accepted beat with in_last, on the same edge:
  - out_data <= acc_base + in_data.
  - out_count <= cnt_base+1 (saturating).
  - out_ovf <= updated ovf.
  - out_valid <= 1.
  - acc, cnt and ovf_st reset to 0.
- Base values: acc_base, cnt_base and ovf_base are 0 when clr is high this cycle, otherwise the current registers. clr is therefore "clear, then add this beat".
- clr without an accepted beat: acc, cnt and ovf_st go to 0. clr never affects a pending output.
- Output handshake:
  - out_valid stays high, and out_data, out_count and out_ovf stay stable, until out_valid && out_ready.
  - On that handshake out_valid drops, unless a new last-beat is accepted the same cycle. In that case out_valid stays 1 and the new result loads (back-to-back, no bubble).
- Latency: one cycle from the last-beat acceptance to out_valid.
- Throughput: one beat per cycle when out_ready is held high.
- States:
  - ACCUM: no pending output.
  - HOLD: out_valid=1.
  - ACCUM->HOLD on last-beat acceptance.
  - HOLD->ACCUM on output handshake without a new last-beat.
  - HOLD->HOLD on handshake with a simultaneous last-beat.
- Width rules: all arithmetic is unsigned. Carry-out is bit ACC_W of the (ACC_W+1)-bit sum.
- Empty packet: a single last-beat gives count 1. Zero-length packets do not exist.
- in_valid low: no state change other than clr and the output handshake.

Decomposition:
- Shared package mac_pkg holds:
  - the ACC_W localparam derivation.
  - the state enum {ACCUM, HOLD}.
  - the default widths.
- No sub-module: a single always block for the registers plus combinational next-state logic.
- The adder stays inline; retiming is left to synthesis.

Test Plan:
- Basic packet: beats 5, 7, 9 (last on 9), out_ready=1 -> one cycle later out_valid=1, out_data=21, out_count=3, out_ovf=0.
- Backpressure: complete a packet with out_ready=0 for 4 cycles -> outputs held stable and in_ready=0. Raise out_ready with a new single last-beat 4 -> handshake and load on the same cycle, out_data=4, count=1, no bubble.
- Overflow: 256 beats of 2^128-1 -> ovf=0, out_data=2^136-256. 257 beats -> out_ovf=1, out_data=2^128-257, out_count=257.
- clr semantics: beats 10, 20, then clr together with beat 3 flagged last -> out_data=3, out_count=1. clr alone while HOLD -> pending result unchanged.
- Reset mid-operation: beats 11, 12, then rst for 1 cycle -> all outputs 0. Then a last-beat of 4 -> out_data=4, out_count=1.
- Streaming: 100 random 2-to-5-beat packets with random out_ready -> scoreboard matches the reference sum and count, and no result is dropped or duplicated.
